muldiv_unit: RTL

Iterative RV64M multiply/divide engine for the execute stage, beside the main ALU. Accepts one M-extension operation (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU) through a valid/ready handshake. Runs a radix-2 shift-add or restoring-subtract sequence, one bit per cycle, and returns the 64-bit result through a second handshake. While an operation is in flight, the core stalls on `busy`.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_sign_fixup.sv | 42 ++++
 rtl/muldiv_unit.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide engine.
package muldiv_pkg;

   localparam int unsigned XLEN = 64;

   // M-extension funct3 encodings (instruction[14:12])
   typedef enum logic [2:0] {
      F3_MUL    = 3'd0,
      F3_MULH   = 3'd1,
      F3_MULHSU = 3'd2,
      F3_MULHU  = 3'd3,
      F3_DIV    = 3'd4,
      F3_DIVU   = 3'd5,
      F3_REM    = 3'd6,
      F3_REMU   = 3'd7
   } funct3_t;

   // Engine states
   typedef logic [1:0] state_t;
   localparam state_t IDLE  = 2'd0;
   localparam state_t CALC  = 2'd1;
   localparam state_t FIXUP = 2'd2;
   localparam state_t DONE  = 2'd3;

   // Iteration counter: 63 for 64-bit ops, 31 for word ops
   typedef logic [5:0] count_t;

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{(XLEN-32){v[31]}}, v};
   endfunction

endpackage

// File: rtl/muldiv_sign_fixup.sv
// Final result shaping: conditional negate, product-half / quotient / remainder select,
// and (with MULDIV_WORD_OPS_EN) sign extension of word results from bit 31.
module muldiv_sign_fixup
   import muldiv_pkg::*;
(
   input  logic [2*XLEN-1:0] prod,
   input  logic [XLEN-1:0]   quot,
   input  logic [XLEN-1:0]   rem,
   input  funct3_t           funct3,
`ifdef MULDIV_WORD_OPS_EN
   input  logic              word,
`endif
   input  logic              neg_res,
   input  logic              neg_rem,
   output logic [XLEN-1:0]   result
);

   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quot_s;
   logic [XLEN-1:0]   rem_s;
   logic [XLEN-1:0]   sel;

   // Apply signs to the unsigned magnitudes and pick the requested field
   always_comb begin
      prod_s = neg_res ? -prod : prod;
      quot_s = neg_res ? -quot : quot;
      rem_s  = neg_rem ? -rem  : rem;
      sel    = '0;
      unique case (funct3)
         F3_MUL:                       sel = prod_s[XLEN-1:0];
         F3_MULH, F3_MULHSU, F3_MULHU: sel = prod_s[2*XLEN-1:XLEN];
         F3_DIV, F3_DIVU:              sel = quot_s;
         default:                      sel = rem_s;
      endcase
`ifdef MULDIV_WORD_OPS_EN
      result = word ? sext32(sel[31:0]) : sel;
`else
      result = sel;
`endif
   end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide engine: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, with request/response handshakes and flush.
// Optional MULDIV_WORD_OPS_EN adds the OP-32 word forms (instruction[3]).
module muldiv_unit
   import muldiv_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     instruction,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [XLEN-1:0] rsp_result,
   output logic            busy
);

   state_t            state_q, state_d;
   count_t            cnt_q, cnt_d;
   funct3_t           f3_q, f3_d;
   logic              neg_res_q, neg_res_d;
   logic              neg_rem_q, neg_rem_d;
   logic [XLEN-1:0]   opa_q, opa_d;      // multiplicand or divisor magnitude
   logic [XLEN-1:0]   opb_q, opb_d;      // multiplier or dividend/quotient shift register
   logic [2*XLEN-1:0] acc_q, acc_d;      // product, or remainder in the low half
   logic [XLEN-1:0]   result_q, result_d;
`ifdef MULDIV_WORD_OPS_EN
   logic              word_q, word_d;
   logic              word_in;
`endif

   funct3_t           f3_in;
   logic              is_div_in, is_rem_in, a_signed, b_signed;
   logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, rem_dvd, min_neg;
   logic              a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0]   special_res, opb_init;
   count_t            cnt_init;
   logic [XLEN:0]     rem_shift, diff;
   logic [2*XLEN-1:0] acc_next;
   logic [XLEN-1:0]   opb_next;
   logic [XLEN-1:0]   fixup_res;

   logic unused_instr;
   assign unused_instr = ^{instruction[31:15], instruction[11:0]};

   // Decode the incoming request: operand extension, magnitudes, sign flags, special cases
   always_comb begin
      f3_in     = funct3_t'(instruction[14:12]);
      is_div_in = instruction[14];
      is_rem_in = instruction[13];
      a_signed  = (f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
                  (f3_in == F3_DIV)  || (f3_in == F3_REM);
      b_signed  = (f3_in == F3_MULH) || (f3_in == F3_DIV) || (f3_in == F3_REM);
      a_ext     = rs1;
      b_ext     = rs2;
      rem_dvd   = rs1;
      min_neg   = 64'h8000_0000_0000_0000;
      cnt_init  = 6'd63;
`ifdef MULDIV_WORD_OPS_EN
      word_in = instruction[3];
      if (word_in) begin
         a_ext    = a_signed ? sext32(rs1[31:0]) : {32'b0, rs1[31:0]};
         b_ext    = b_signed ? sext32(rs2[31:0]) : {32'b0, rs2[31:0]};
         rem_dvd  = sext32(rs1[31:0]);
         min_neg  = 64'hFFFF_FFFF_8000_0000;
         cnt_init = 6'd31;
      end
`endif
      a_neg    = a_signed & a_ext[XLEN-1];
      b_neg    = b_signed & b_ext[XLEN-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;
      div_zero = is_div_in && (b_ext == '0);
      div_ovf  = is_div_in && b_signed && (a_ext == min_neg) && (b_ext == '1);
      if (div_zero) special_res = is_rem_in ? rem_dvd : '1;
      else          special_res = is_rem_in ? '0 : a_ext;
      // Word ops start with the 32 live bits at the top so the MSB-first loop sees them first
      opb_init = is_div_in ? a_mag : b_mag;
`ifdef MULDIV_WORD_OPS_EN
      if (word_in) opb_init = {opb_init[31:0], 32'b0};
`endif
   end

   // One shift-add or restoring-subtract step on the current state
   always_comb begin
      rem_shift = {acc_q[XLEN-1:0], opb_q[XLEN-1]};
      diff      = rem_shift - {1'b0, opa_q};
      if (f3_q[2]) begin
         acc_next = {{XLEN{1'b0}}, diff[XLEN] ? rem_shift[XLEN-1:0] : diff[XLEN-1:0]};
         opb_next = {opb_q[XLEN-2:0], ~diff[XLEN]};
      end else begin
         acc_next = {acc_q[2*XLEN-2:0], 1'b0} +
                    (opb_q[XLEN-1] ? {{XLEN{1'b0}}, opa_q} : {(2*XLEN){1'b0}});
         opb_next = {opb_q[XLEN-2:0], 1'b0};
      end
   end

   muldiv_sign_fixup u_fixup (
      .prod    (acc_q),
      .quot    (opb_q),
      .rem     (acc_q[XLEN-1:0]),
      .funct3  (f3_q),
`ifdef MULDIV_WORD_OPS_EN
      .word    (word_q),
`endif
      .neg_res (neg_res_q),
      .neg_rem (neg_rem_q),
      .result  (fixup_res)
   );

   // FSM next state; flush overrides every transition including a same-cycle request
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      f3_d      = f3_q;
      neg_res_d = neg_res_q;
      neg_rem_d = neg_rem_q;
      opa_d     = opa_q;
      opb_d     = opb_q;
      acc_d     = acc_q;
      result_d  = result_q;
`ifdef MULDIV_WORD_OPS_EN
      word_d    = word_q;
`endif
      if (flush) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  f3_d      = f3_in;
                  neg_res_d = a_neg ^ b_neg;
                  neg_rem_d = a_neg;
                  cnt_d     = cnt_init;
                  opa_d     = is_div_in ? b_mag : a_mag;
                  opb_d     = opb_init;
                  acc_d     = '0;
`ifdef MULDIV_WORD_OPS_EN
                  word_d    = word_in;
`endif
                  if (div_zero || div_ovf) begin
                     result_d = special_res;
                     state_d  = DONE;
                  end else begin
                     state_d  = CALC;
                  end
               end
            end
            CALC: begin
               acc_d = acc_next;
               opb_d = opb_next;
               if (cnt_q == 6'd0) state_d = FIXUP;
               else               cnt_d   = cnt_q - 6'd1;
            end
            FIXUP: begin
               result_d = fixup_res;
               state_d  = DONE;
            end
            DONE: begin
               if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         f3_q      <= F3_MUL;
         neg_res_q <= 1'b0;
         neg_rem_q <= 1'b0;
         opa_q     <= '0;
         opb_q     <= '0;
         acc_q     <= '0;
         result_q  <= '0;
`ifdef MULDIV_WORD_OPS_EN
         word_q    <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         f3_q      <= f3_d;
         neg_res_q <= neg_res_d;
         neg_rem_q <= neg_rem_d;
         opa_q     <= opa_d;
         opb_q     <= opb_d;
         acc_q     <= acc_d;
         result_q  <= result_d;
`ifdef MULDIV_WORD_OPS_EN
         word_q    <= word_d;
`endif
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE);
   assign rsp_valid  = (state_q == DONE);
   assign rsp_result = result_q;

endmodule
